// File: rtl/prach_unreshape1.sv
// prach_unreshape1: restores per-sample (re, im) order from the packed dp1/dp2
// stream. Each lane buffers one block of SIZE beats in a ping-pong store. The
// block is then drained in natural sample order, one beat per cycle.
// Optional feature macro: PRACH_UNRESHAPE_ERR_EN (err pulse on discard / chn change).
module prach_unreshape1 #(
    parameter int unsigned NUM_LANES = 3,
    parameter int unsigned SIZE      = 8,
    parameter int unsigned WIDTH     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH*NUM_LANES-1:0]   din_dp1,
    input  logic [WIDTH*NUM_LANES-1:0]   din_dp2,
    input  logic                         din_dv,
    input  logic [7:0]                   din_chn,
    input  logic                         sync_in,
    output logic [WIDTH*NUM_LANES-1:0]   dout_dr,
    output logic [WIDTH*NUM_LANES-1:0]   dout_di,
    output logic                         dout_dv,
    output logic [7:0]                   dout_chn,
    output logic                         sync_out,
    output logic                         err
);

    localparam int unsigned AW = $clog2(SIZE);

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    // Control state
    state_t          state_q, state_d;
    logic [AW-1:0]   wcnt_q, wcnt_d;
    logic [AW-1:0]   rcnt_q, rcnt_d;
    logic            wbank_q, wbank_d;
    logic            rbank_q, rbank_d;
    logic            pend_q, pend_d;
    logic [7:0]      cur_chn_q, cur_chn_d;
    logic            cur_sync_q, cur_sync_d;
    logic [7:0]      bank_chn_q [2];
    logic [7:0]      bank_chn_d [2];
    logic            bank_sync_q [2];
    logic            bank_sync_d [2];

    // Per-lane ping-pong storage of the packed words
    logic [WIDTH-1:0] mem1_q [NUM_LANES][2][SIZE];
    logic [WIDTH-1:0] mem1_d [NUM_LANES][2][SIZE];
    logic [WIDTH-1:0] mem2_q [NUM_LANES][2][SIZE];
    logic [WIDTH-1:0] mem2_d [NUM_LANES][2][SIZE];

    // Registered outputs
    logic [WIDTH*NUM_LANES-1:0] dr_q, dr_d;
    logic [WIDTH*NUM_LANES-1:0] di_q, di_d;
    logic                       dv_q, dv_d;
    logic [7:0]                 chn_q, chn_d;
    logic                       sync_out_q, sync_out_d;
    logic                       err_q, err_d;

`ifdef PRACH_UNRESHAPE_ERR_EN
    logic chn_bad_q, chn_bad_d;
`endif

    // Write-side helpers
    logic [AW-1:0] widx;
    logic          restart;
    logic          complete;
    logic [AW-1:0] ra_e;
    logic [AW-1:0] ra_o;

    // Write side: beat placement, block completion, bank flip and tag latching
    always_comb begin
        mem1_d      = mem1_q;
        mem2_d      = mem2_q;
        wcnt_d      = wcnt_q;
        wbank_d     = wbank_q;
        cur_chn_d   = cur_chn_q;
        cur_sync_d  = cur_sync_q;
        bank_chn_d  = bank_chn_q;
        bank_sync_d = bank_sync_q;
        err_d       = 1'b0;
`ifdef PRACH_UNRESHAPE_ERR_EN
        chn_bad_d   = chn_bad_q;
`endif

        // A sync on a mid-block beat drops the partial block and restarts at index 0
        widx     = sync_in ? '0 : wcnt_q;
        restart  = din_dv && sync_in && (wcnt_q != '0);
        complete = din_dv && (widx == AW'(SIZE - 1));

        if (din_dv) begin
            for (int unsigned l = 0; l < NUM_LANES; l++) begin
                mem1_d[l][wbank_q][widx] = din_dp1[l*WIDTH +: WIDTH];
                mem2_d[l][wbank_q][widx] = din_dp2[l*WIDTH +: WIDTH];
            end
            wcnt_d = widx + AW'(1);
            if (widx == '0) begin
                cur_chn_d  = din_chn;
                cur_sync_d = sync_in;
`ifdef PRACH_UNRESHAPE_ERR_EN
                chn_bad_d  = 1'b0;
`endif
            end
            if (complete) begin
                wcnt_d                = '0;
                wbank_d               = ~wbank_q;
                bank_chn_d[wbank_q]   = cur_chn_q;
                bank_sync_d[wbank_q]  = cur_sync_q;
            end
        end

`ifdef PRACH_UNRESHAPE_ERR_EN
        // Only the first chn mismatch of a block raises err
        if (restart) begin
            err_d = 1'b1;
        end else if (din_dv && (widx != '0) && (din_chn != cur_chn_q) && !chn_bad_q) begin
            err_d     = 1'b1;
            chn_bad_d = 1'b1;
        end
`else
        err_d = restart & 1'b0;
`endif
    end

    // Read side: IDLE/DRAIN sequencing and natural-order unpack into output regs
    always_comb begin
        state_d    = state_q;
        rcnt_d     = rcnt_q;
        rbank_d    = rbank_q;
        pend_d     = pend_q;
        dr_d       = dr_q;
        di_d       = di_q;
        chn_d      = chn_q;
        dv_d       = 1'b0;
        sync_out_d = 1'b0;

        // Sample k: first half lives in dp1 at beats 2k/2k+1, second half in dp2
        ra_e = {rcnt_q[AW-2:0], 1'b0};
        ra_o = {rcnt_q[AW-2:0], 1'b1};

        case (state_q)
            IDLE: begin
                if (complete) begin
                    state_d = DRAIN;
                    rcnt_d  = '0;
                    rbank_d = wbank_q;
                end
            end
            DRAIN: begin
                dv_d       = 1'b1;
                chn_d      = bank_chn_q[rbank_q];
                sync_out_d = (rcnt_q == '0) && bank_sync_q[rbank_q];
                for (int unsigned l = 0; l < NUM_LANES; l++) begin
                    if (rcnt_q[AW-1]) begin
                        dr_d[l*WIDTH +: WIDTH] = mem2_q[l][rbank_q][ra_e];
                        di_d[l*WIDTH +: WIDTH] = mem2_q[l][rbank_q][ra_o];
                    end else begin
                        dr_d[l*WIDTH +: WIDTH] = mem1_q[l][rbank_q][ra_e];
                        di_d[l*WIDTH +: WIDTH] = mem1_q[l][rbank_q][ra_o];
                    end
                end
                if (rcnt_q == AW'(SIZE - 1)) begin
                    if (pend_q || complete) begin
                        rcnt_d  = '0;
                        rbank_d = ~rbank_q;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    rcnt_d = rcnt_q + AW'(1);
                    if (complete) begin
                        pend_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            wbank_q     <= 1'b0;
            rbank_q     <= 1'b0;
            pend_q      <= 1'b0;
            cur_chn_q   <= '0;
            cur_sync_q  <= 1'b0;
            bank_chn_q  <= '{default: '0};
            bank_sync_q <= '{default: 1'b0};
            mem1_q      <= '{default: '0};
            mem2_q      <= '{default: '0};
            dr_q        <= '0;
            di_q        <= '0;
            dv_q        <= 1'b0;
            chn_q       <= '0;
            sync_out_q  <= 1'b0;
            err_q       <= 1'b0;
`ifdef PRACH_UNRESHAPE_ERR_EN
            chn_bad_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            wbank_q     <= wbank_d;
            rbank_q     <= rbank_d;
            pend_q      <= pend_d;
            cur_chn_q   <= cur_chn_d;
            cur_sync_q  <= cur_sync_d;
            bank_chn_q  <= bank_chn_d;
            bank_sync_q <= bank_sync_d;
            mem1_q      <= mem1_d;
            mem2_q      <= mem2_d;
            dr_q        <= dr_d;
            di_q        <= di_d;
            dv_q        <= dv_d;
            chn_q       <= chn_d;
            sync_out_q  <= sync_out_d;
            err_q       <= err_d;
`ifdef PRACH_UNRESHAPE_ERR_EN
            chn_bad_q   <= chn_bad_d;
`endif
        end
    end

    assign dout_dr  = dr_q;
    assign dout_di  = di_q;
    assign dout_dv  = dv_q;
    assign dout_chn = chn_q;
    assign sync_out = sync_out_q;
    assign err      = err_q;

endmodule

// File: tb/tb_prach_unreshape1.sv
// tb_prach_unreshape1: directed bench for prach_unreshape1 (3 lanes, SIZE 8, WIDTH 16).
// Blocks are packed here from known (re, im) samples; the output stream is
// compared beat by beat, including arrival time, against those samples.
module tb_prach_unreshape1;

    localparam int L = 3;
    localparam int W = 16;
    localparam int S = 8;

`ifdef PRACH_UNRESHAPE_ERR_EN
    localparam int ERR_ON = 1;
`else
    localparam int ERR_ON = 0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [W*L-1:0] din_dp1, din_dp2;
    logic           din_dv;
    logic [7:0]     din_chn;
    logic           sync_in;
    logic [W*L-1:0] dout_dr, dout_di;
    logic           dout_dv;
    logic [7:0]     dout_chn;
    logic           sync_out;
    logic           err;

    prach_unreshape1 #(.NUM_LANES(L), .SIZE(S), .WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .din_dp1(din_dp1), .din_dp2(din_dp2), .din_dv(din_dv),
        .din_chn(din_chn), .sync_in(sync_in),
        .dout_dr(dout_dr), .dout_di(dout_di), .dout_dv(dout_dv),
        .dout_chn(dout_chn), .sync_out(sync_out), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint         t;
        logic [W*L-1:0] dr;
        logic [W*L-1:0] di;
        logic [7:0]     chn;
        logic           sync;
    } beat_t;

    beat_t got_q[$];
    beat_t exp_q[$];
    int    n_tests  = 0;
    int    n_fail   = 0;
    int    err_cnt  = 0;
    int    err_base = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (dout_dv) got_q.push_back('{$time, dout_dr, dout_di, dout_chn, sync_out});
        if (err) err_cnt++;
    end

    function automatic logic [15:0] samp(input int l, input int s, input int k, input bit im);
        return 16'(s + l*1000 + k + (im ? 100 : 0));
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Drive packed beats j0..j1 of block 'seed'; queue nexp expected output beats on completion
    task automatic send_beats(input int seed, input logic [7:0] chn, input int j0, input int j1,
                              input int gap, input int nexp, input int alt_at, input logic [7:0] alt_chn);
        longint tcap;
        beat_t  e;
        tcap = 0;
        for (int j = j0; j <= j1; j++) begin
            din_dv  = 1'b1;
            din_chn = (alt_at >= 0 && j >= alt_at) ? alt_chn : chn;
            sync_in = (j == 0);
            for (int l = 0; l < L; l++) begin
                din_dp1[l*W +: W] = samp(l, seed, j/2, bit'(j%2));
                din_dp2[l*W +: W] = samp(l, seed, S/2 + j/2, bit'(j%2));
            end
            @(posedge clk);
            tcap = $time;
            #1;
            din_dv  = 1'b0;
            sync_in = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
        if (j1 == S-1) begin
            for (int k = 0; k < nexp; k++) begin
                e.t = tcap + 15 + 10*k;
                for (int l = 0; l < L; l++) begin
                    e.dr[l*W +: W] = samp(l, seed, k, 1'b0);
                    e.di[l*W +: W] = samp(l, seed, k, 1'b1);
                end
                e.chn  = chn;
                e.sync = (k == 0);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic check_out(input string tag, input int exp_err);
        int n;
        check($sformatf("%s.count", tag), 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s.b%0d.time", tag, i), 64'(got_q[i].t),    64'(exp_q[i].t));
            check($sformatf("%s.b%0d.dr",   tag, i), 64'(got_q[i].dr),   64'(exp_q[i].dr));
            check($sformatf("%s.b%0d.di",   tag, i), 64'(got_q[i].di),   64'(exp_q[i].di));
            check($sformatf("%s.b%0d.chn",  tag, i), 64'(got_q[i].chn),  64'(exp_q[i].chn));
            check($sformatf("%s.b%0d.sync", tag, i), 64'(got_q[i].sync), 64'(exp_q[i].sync));
        end
        check($sformatf("%s.err", tag), 64'(err_cnt - err_base), 64'(exp_err));
        got_q.delete();
        exp_q.delete();
        err_base = err_cnt;
    endtask

    task automatic check_zero(input string tag);
        check($sformatf("%s.dv", tag),   64'(dout_dv),  64'd0);
        check($sformatf("%s.dr", tag),   64'(dout_dr),  64'd0);
        check($sformatf("%s.di", tag),   64'(dout_di),  64'd0);
        check($sformatf("%s.chn", tag),  64'(dout_chn), 64'd0);
        check($sformatf("%s.sync", tag), 64'(sync_out), 64'd0);
        check($sformatf("%s.err", tag),  64'(err),      64'd0);
    endtask

    initial begin
        rst = 1'b1; din_dv = 1'b0; din_chn = '0; sync_in = 1'b0;
        din_dp1 = '0; din_dp2 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #4 check_zero("reset");
        @(posedge clk); #1;

        // 1: single block, lane 0 samples re=k, im=100+k
        send_beats(0, 8'd5, 0, S-1, 0, S, -1, 8'd0);
        idle(20);
        check_out("t1_single", 0);

        // 2: four back-to-back blocks on continuous din_dv
        for (int b = 0; b < 4; b++) send_beats(200*(b+1), 8'(b), 0, S-1, 0, S, -1, 8'd0);
        idle(20);
        check_out("t2_contig", 0);

        // 3: din_dv every third cycle
        send_beats(1200, 8'd4, 0, S-1, 2, S, -1, 8'd0);
        send_beats(1400, 8'd6, 0, S-1, 2, S, -1, 8'd0);
        idle(20);
        check_out("t3_gaps", 0);

        // 4: sync at beat 5 drops the partial block
        send_beats(1600, 8'd7, 0, 4, 0, 0, -1, 8'd0);
        send_beats(1800, 8'd8, 0, S-1, 0, S, -1, 8'd0);
        idle(20);
        check_out("t4_resync", ERR_ON);

        // 5: chn changes from beat 3 on; block keeps its beat-0 tag
        send_beats(2000, 8'd9, 0, S-1, 0, S, 3, 8'd10);
        idle(20);
        check_out("t5_chn", ERR_ON);

        // 6: reset during the fourth cycle of a drain
        send_beats(2200, 8'd11, 0, S-1, 0, 3, -1, 8'd0);
        idle(3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #4 check_zero("t6_rst");
        @(posedge clk); #1;
        idle(20);
        check_out("t6a_abort", 0);
        send_beats(2400, 8'd12, 0, S-1, 0, S, -1, 8'd0);
        idle(20);
        check_out("t6b_clean", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
